matrix_scan_controller: RTL and testbench

//  Time-multiplexes a 5x7 LED matrix: scans one column at a time and drives the shared active-low row lines with that column's pattern.

---
 rtl/matrix_pkg.sv | 37 +++
 rtl/matrix_slot_timer.sv | 48 ++++
 rtl/matrix_scan_controller.sv | 165 ++++++++++++++++
 tb/tb_matrix_scan_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// ============================================================================
//  Module : matrix_pkg
//  Shared geometry constants and display state encodings for the 5x7 matrix.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

    localparam int MATRIX_COLS = 5;
    localparam int MATRIX_ROWS = 7;
    localparam int COL_W       = 3;

    localparam logic [MATRIX_ROWS-1:0] ROW_OFF  = 7'b1111111;
    localparam logic [COL_W-1:0]       COL_LAST = 3'd4;
    localparam logic [COL_W-1:0]       COL_ONE  = 3'd1;

    typedef enum logic [1:0] {
        DISP_IDLE  = 2'd0,
        DISP_BLANK = 2'd1,
        DISP_DRIVE = 2'd2
    } disp_state_t;

    function automatic logic [MATRIX_COLS-1:0] col_onehot(input logic [COL_W-1:0] col);
        logic [MATRIX_COLS-1:0] oh;
        oh = '0;
        for (int i = 0; i < MATRIX_COLS; i++) begin
            if (col == COL_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_slot_timer.sv
// ============================================================================
//  Module : matrix_slot_timer
//  Column slot counter; strobes the last blank cycle and the last slot cycle.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module matrix_slot_timer #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic blank_done,
    output logic slot_done
);

    localparam int            CW           = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_SLOT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] C_ONE        = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + C_ONE;
        if (clear || (cnt_q == C_SLOT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Strobes are suppressed while cleared so a parked scanner never advances.
    assign blank_done = !clear && (cnt_q == C_BLANK_LAST);
    assign slot_done  = !clear && (cnt_q == C_SLOT_LAST);

endmodule

`default_nettype wire

// File: rtl/matrix_scan_controller.sv
// ============================================================================
//  Module : matrix_scan_controller
//  Column-multiplexed 5x7 LED scanner with frame-boundary latch and blink.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int BLANK        = 500,
    parameter int BLINK_FRAMES = 100
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       blink,
    input  logic [6:0] column_4,
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [6:0] rows,
    output logic [4:0] col_en,
    output logic       frame_done
);

    localparam int            FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] C_FLAST = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] C_FONE  = FW'(1);

    typedef logic [MATRIX_COLS-1:0][MATRIX_ROWS-1:0] image_t;

    disp_state_t            state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    image_t                 img_q, img_d;
    logic                   blink_q, blink_d;
    logic                   phase_on_q, phase_on_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic [MATRIX_ROWS-1:0] rows_q, rows_d;
    logic [MATRIX_COLS-1:0] col_en_q, col_en_d;
    logic                   frame_done_q, frame_done_d;

    image_t w_image;
    logic   w_timer_clear;
    logic   w_blank_done;
    logic   w_slot_done;

    assign w_image       = {column_4, column_3, column_2, column_1, column_0};
    assign w_timer_clear = !enable || (state_q == DISP_IDLE);

    matrix_slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_slot_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (w_timer_clear),
        .blank_done (w_blank_done),
        .slot_done  (w_slot_done)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        img_d        = img_q;
        blink_d      = blink_q;
        phase_on_d   = phase_on_q;
        fcnt_d       = fcnt_q;
        frame_done_d = 1'b0;
        rows_d       = ROW_OFF;
        col_en_d     = '0;

        if (!blink_q) begin
            phase_on_d = 1'b1;
            fcnt_d     = '0;
        end

        if (!enable) begin
            state_d    = DISP_IDLE;
            col_d      = COL_LAST;
            phase_on_d = 1'b1;
            fcnt_d     = '0;
        end else begin
            case (state_q)
                DISP_IDLE: begin
                    img_d   = w_image;
                    blink_d = blink;
                    col_d   = COL_LAST;
                    state_d = DISP_BLANK;
                end
                DISP_BLANK: begin
                    if (w_blank_done) begin
                        state_d = DISP_DRIVE;
                    end
                end
                DISP_DRIVE: begin
                    if (w_slot_done) begin
                        state_d = DISP_BLANK;
                        if (col_q != '0) begin
                            col_d = col_q - COL_ONE;
                        end else begin
                            // Frame boundary: the blink count belongs to the frame just shown.
                            frame_done_d = 1'b1;
                            col_d        = COL_LAST;
                            img_d        = w_image;
                            blink_d      = blink;
                            if (blink_q) begin
                                if (fcnt_q == C_FLAST) begin
                                    fcnt_d     = '0;
                                    phase_on_d = !phase_on_q;
                                end else begin
                                    fcnt_d = fcnt_q + C_FONE;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = DISP_IDLE;
                    col_d   = COL_LAST;
                end
            endcase
        end

        if (state_d == DISP_DRIVE) begin
            col_en_d = col_onehot(col_d);
            if (phase_on_d) begin
                rows_d = img_d[col_d];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= DISP_IDLE;
            col_q        <= COL_LAST;
            img_q        <= {MATRIX_COLS{ROW_OFF}};
            blink_q      <= 1'b0;
            phase_on_q   <= 1'b1;
            fcnt_q       <= '0;
            rows_q       <= ROW_OFF;
            col_en_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            img_q        <= img_d;
            blink_q      <= blink_d;
            phase_on_q   <= phase_on_d;
            fcnt_q       <= fcnt_d;
            rows_q       <= rows_d;
            col_en_q     <= col_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rows       = rows_q;
    assign col_en     = col_en_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_controller.sv
// ============================================================================
//  Module : tb_matrix_scan_controller
//  Directed and random scan sequences checked against a frame-level model.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_scan_controller;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = 5 * DIV;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       blink;
    logic [6:0] cin [5];
    logic [6:0] rows;
    logic [4:0] col_en;
    logic       frame_done;

    int         k;
    logic [6:0] m_img [5];
    bit         m_blink;
    bit         m_phase;
    int         m_cnt;
    int         vectors;
    int         miscompares;

    matrix_scan_controller #(
        .DIV          (DIV),
        .BLANK        (BLANK),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .blink      (blink),
        .column_4   (cin[4]),
        .column_3   (cin[3]),
        .column_2   (cin[2]),
        .column_1   (cin[1]),
        .column_0   (cin[0]),
        .rows       (rows),
        .col_en     (col_en),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic latch_image();
        for (int i = 0; i < 5; i++) m_img[i] = cin[i];
        m_blink = blink;
        if (!m_blink) begin
            m_phase = 1'b1;
            m_cnt   = 0;
        end
    endtask

    // k counts edges since the scanner left IDLE; -1 means parked/dark.
    task automatic model_edge();
        if (!reset_n || !enable) begin
            k       = -1;
            m_phase = 1'b1;
            m_cnt   = 0;
            if (!reset_n) m_blink = 1'b0;
        end else if (k < 0) begin
            k = 0;
            latch_image();
        end else begin
            k++;
            if (k % FRAME == 0) begin
                if (m_blink) begin
                    m_cnt++;
                    if (m_cnt == BF) begin
                        m_cnt   = 0;
                        m_phase = !m_phase;
                    end
                end
                latch_image();
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [6:0] er;
        logic [4:0] ec;
        logic       ef;
        int         col;
        er = 7'h7F;
        ec = 5'b0;
        ef = 1'b0;
        if (k >= 0) begin
            col = 4 - (k % FRAME) / DIV;
            if (k % DIV >= BLANK) begin
                ec = 5'(1 << col);
                if (m_phase) er = m_img[col];
            end
            ef = (k > 0) && (k % FRAME == 0);
        end
        vectors++;
        assert (rows === er) else begin
            miscompares++;
            $error("FAIL %s rows: observed %b expected %b (k=%0d)", tag, rows, er, k);
        end
        vectors++;
        assert (col_en === ec) else begin
            miscompares++;
            $error("FAIL %s col_en: observed %b expected %b (k=%0d)", tag, col_en, ec, k);
        end
        vectors++;
        assert (frame_done === ef) else begin
            miscompares++;
            $error("FAIL %s frame_done: observed %b expected %b (k=%0d)", tag, frame_done, ef, k);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic wait_k(input int target, input int modulus, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step(tag);
            if (k >= 0 && (k % modulus) == target) hit = 1'b1;
        end
        vectors++;
        assert (hit) else begin
            miscompares++;
            $error("FAIL %s wait: observed timeout expected k%%%0d==%0d", tag, modulus, target);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        k           = -1;
        m_phase     = 1'b1;
        m_cnt       = 0;
        m_blink     = 1'b0;
        for (int i = 0; i < 5; i++) m_img[i] = 7'h7F;

        reset_n = 1'b0;
        enable  = 1'b1;
        blink   = 1'b0;
        for (int i = 0; i < 5; i++) cin[i] = 7'($urandom);
        #2;
        repeat (3) step("reset");

        cin[4] = 7'b1101111;
        cin[3] = 7'b1011111;
        cin[2] = 7'b0000000;
        cin[1] = 7'b1011111;
        cin[0] = 7'b1101111;
        reset_n = 1'b1;
        step("start");
        for (int i = 0; i < 90; i++) begin
            if (k == 10) for (int j = 0; j < 5; j++) cin[j] = 7'h7F;
            step("fill");
        end

        for (int i = 0; i < 5; i++) cin[i] = 7'($urandom);
        for (int i = 0; i < 80; i++) begin
            if (i % 7 == 3) cin[$urandom_range(0, 4)] = 7'($urandom);
            step("latch");
        end

        enable = 1'b0;
        step("park");
        blink = 1'b1;
        for (int i = 0; i < 5; i++) cin[i] = 7'($urandom);
        enable = 1'b1;
        for (int i = 0; i < 5 * FRAME + 10; i++) begin
            if (i % 13 == 5) cin[$urandom_range(0, 4)] = 7'($urandom);
            step("blink");
        end
        blink = 1'b0;
        for (int i = 0; i < 100; i++) step("unblink");

        wait_k(20, FRAME, "col2");
        enable = 1'b0;
        step("disable");
        step("parked");
        enable = 1'b1;
        for (int i = 0; i < 20; i++) step("reenable");

        wait_k(FRAME - 1, FRAME, "preend");
        enable = 1'b0;
        step("disable_at_end");
        enable = 1'b1;
        for (int i = 0; i < 12; i++) step("reenable2");

        wait_k(4, DIV, "drive");
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        assert (rows === 7'h7F && col_en === 5'b0 && frame_done === 1'b0) else begin
            miscompares++;
            $error("FAIL async_reset: observed rows=%b col_en=%b fd=%b expected 1111111/00000/0",
                   rows, col_en, frame_done);
        end
        step("in_reset");
        reset_n = 1'b1;
        for (int i = 0; i < 45; i++) step("post_reset");

        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 149) == 0) blink = !blink;
            if ($urandom_range(0, 9) == 0) cin[$urandom_range(0, 4)] = 7'($urandom);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
